ag_io_page: RTL and testbench
=============================

// Module: ag_io_page
// PURPOSE
//  Parametrised C0xx soft-switch/I-O page for the Agat core, clocked on phi_2 next to the CPU.
//  Decodes CPU accesses and provides:
//   - keyboard latch with strobe flag;
//   - two legacy toggles (tape, beep) plus NUM_EXTRA extra toggle channels;
//   - video-mode latch;
//   - programmable interval timer driving NMI.
//  The parent drives the shared read bus from dout/dout_en.
// PARAMETERS
//  NUM_EXTRA  3      extra toggle channels, 0..7, mapped at groups C08X..C0(7+NUM_EXTRA)X
//  TIMER_W    16     timer counter/period width, 8..16
//  PERIOD_RST 20000  period register reset value (phi_2 cycles)
//  VMODE_RST  8'h00  vmode reset value
// PORTS
//  phi_2      in   1            CPU phase-2 clock; all state changes on its rising edge
//  reset      in   1            synchronous, active-high
//  AB         in   16           CPU address bus
//  read       in   1            1 = CPU read cycle, 0 = write
//  DO         in   8            CPU write data
//  key_code   in   7            keyboard code, valid with key_strobe
//  key_strobe in   1            one-cycle new-key pulse
//  dout       out  8            read data for this page
//  dout_en    out  1            1 = dout must drive CPU DI
//  tape_out   out  1            toggle channel, group C02X
//  beep       out  1            toggle channel, group C03X
//  extra_tgl  out  NUM_EXTRA    extra toggle channels (bit i at group 8+i)
//  vmode      out  8            video mode latch
//  nmi        out  1            active-high NMI request (parent inverts for CPU)
//  vsync      in   1            only with AG_IO_VSYNC_NMI_EN
// BEHAVIOUR
//  Decode: page = AB[15:8]==8'hC0; group g = AB[7:4].
//   - Every phi_2 edge with a decoded address counts as one access, dummy cycles included.
//   - Toggles and strobes act on reads and writes alike.
//  C00X read: dout = {kbd_flag, kbd_code[6:0]}, dout_en=1 (combinational, same cycle).
//  C01X any access: kbd_flag <= 0.
//  key_strobe: kbd_code <= key_code, kbd_flag <= 1. Coincident with C01X: strobe wins, flag = 1.
//  C02X / C03X: tape_out / beep invert.
//  C08X+i, i < NUM_EXTRA: extra_tgl[i] inverts. Groups at or above 8+NUM_EXTRA are ignored.
//  C04X: tmr_en <= 1, tmr_flag <= 0, cnt <= period.
//  C05X: tmr_en <= 0, tmr_flag <= 0.
//  C06X write, AB[0]=0: period[7:0] <= DO.
//  C06X write, AB[0]=1: period[TIMER_W-1:8] <= DO[TIMER_W-9:0]; no-op when TIMER_W == 8.
//   - Writes to period never touch cnt.
//  C0FX read: dout = {tmr_flag, tmr_en, 6'b0}, dout_en=1.
//  All other addresses: dout_en=0, dout=8'h00.
//  Cxxx with AB[11:8]==4'h7 (C7XX, any access): vmode <= AB[7:0].
//  Timer (tmr_en=1, period!=0), each cycle:
//   - cnt==1: tmr_flag <= 1, cnt <= period;
//   - otherwise: cnt <= cnt-1.
//   - Expiry interval is exactly period cycles; flag stays set until C04X/C05X/reset.
//   - A C04X/C05X access in the expiry cycle wins and the flag stays 0.
//   - tmr_en=0: cnt holds.
//  nmi = tmr_en & tmr_flag (registered inputs, no combinational path from AB).
//  period==0 with tmr_en: counter stops, no expiry (subject to option below).
//  reset (wins over all):
//   - toggles 0, extra_tgl 0, kbd_flag 0, kbd_code 0;
//   - tmr_en 0, tmr_flag 0, cnt 0, nmi 0;
//   - period=PERIOD_RST, vmode=VMODE_RST.
// CONFIGURATION
//  AG_IO_VSYNC_NMI_EN defined:
//   - vsync port present.
//   - When period==0: nmi = tmr_en & vsync (legacy frame interrupt); counter idle.
//   - When period!=0: internal timer as above.
//  AG_IO_VSYNC_NMI_EN undefined:
//   - no vsync port.
//   - nmi comes only from the internal timer.
// TESTING
//  T1 reset, then key_strobe with key_code=7'h41, then read C000:
//     dout=8'hC1, dout_en=1; access C010, then read C000 -> 8'h41.
//  T2 key_strobe and C010 access in the same cycle -> kbd_flag=1.
//     Single C020 access -> tape_out=1; second C020 -> tape_out=0.
//  T3 NUM_EXTRA=3, access C08X and C0AX -> extra_tgl=3'b101.
//     Access C0BX -> no change. Write C700 region AB=C7A5 -> vmode=8'hA5.
//  T4 write C060=8'h0A, C061=8'h00, then access C040:
//     nmi rises exactly 10 cycles later and stays high.
//     C040 clears nmi; next nmi 10 cycles after that. C050 -> nmi=0, no further expiry.
//  T5 reset asserted mid-count with nmi=1 -> next edge: nmi=0, tape_out=0,
//     period=PERIOD_RST, C0F0 reads 8'h00.
//  T6 (AG_IO_VSYNC_NMI_EN) period=0, C040 access, vsync=1 -> nmi=1; vsync=0 -> nmi=0.

Source files
------------

// File: rtl/ag_io_page.sv
// ag_io_page: C0xx soft-switch / I-O page with keyboard latch, toggles, video-mode latch and interval timer NMI
// Ports: phi_2/reset clock and synchronous reset; AB/read/DO CPU bus; key_code/key_strobe keyboard;
//        dout/dout_en page read data; tape_out/beep/extra_tgl toggle outputs; vmode video latch; nmi request.
// Option AG_IO_VSYNC_NMI_EN: adds the vsync input; with period 0 the NMI follows vsync instead of the timer.
module ag_io_page #(
    parameter int         NUM_EXTRA  = 3,
    parameter int         TIMER_W    = 16,
    parameter int         PERIOD_RST = 20000,
    parameter logic [7:0] VMODE_RST  = 8'h00
) (
    input  logic                                       phi_2,
    input  logic                                       reset,
    input  logic [15:0]                                AB,
    input  logic                                       read,
    input  logic [7:0]                                 DO,
    input  logic [6:0]                                 key_code,
    input  logic                                       key_strobe,
`ifdef AG_IO_VSYNC_NMI_EN
    input  logic                                       vsync,
`endif
    output logic [7:0]                                 dout,
    output logic                                       dout_en,
    output logic                                       tape_out,
    output logic                                       beep,
    output logic [(NUM_EXTRA > 0 ? NUM_EXTRA : 1)-1:0] extra_tgl,
    output logic [7:0]                                 vmode,
    output logic                                       nmi
);
    localparam int EW = NUM_EXTRA > 0 ? NUM_EXTRA : 1;
    localparam logic [EW-1:0] XMASK = EW'((1 << NUM_EXTRA) - 1);
    logic               r_kflag, r_tape, r_beep, r_en, r_tflag;
    logic [6:0]         r_kcode;
    logic [EW-1:0]      r_extra;
    logic [7:0]         r_vmode;
    logic [TIMER_W-1:0] r_period, r_cnt;
    logic [15:0]        w_acc;
    logic [15:0]        w_wide;
    logic [TIMER_W-1:0] w_period_wr;
    logic               w_run;
    // one-hot group hit, zero when the address is outside the C0xx page
    assign w_acc = (AB[15:8] == 8'hC0) ? 16'(1) << AB[7:4] : 16'h0000;
    // high-byte write lands DO above the kept low byte; for an 8-bit timer this leaves period unchanged
    assign w_wide = {DO, r_period[7:0]};
    assign w_period_wr = AB[0] ? w_wide[TIMER_W-1:0] : (r_period & ~TIMER_W'(8'hFF)) | TIMER_W'(DO);
    assign w_run = r_en && r_period != '0;
    assign dout = !read ? 8'h00 : w_acc[0] ? {r_kflag, r_kcode} : w_acc[15] ? {r_tflag, r_en, 6'b0} : 8'h00;
    assign dout_en = read & (w_acc[0] | w_acc[15]);
    assign tape_out = r_tape;
    assign beep = r_beep;
    assign extra_tgl = r_extra;
    assign vmode = r_vmode;
`ifdef AG_IO_VSYNC_NMI_EN
    assign nmi = r_en & (r_period == '0 ? vsync : r_tflag);
`else
    assign nmi = r_en & r_tflag;
`endif
    always_ff @(posedge phi_2) begin
        if (reset) begin
            r_kflag  <= 1'b0;
            r_kcode  <= 7'h00;
            r_tape   <= 1'b0;
            r_beep   <= 1'b0;
            r_extra  <= '0;
            r_vmode  <= VMODE_RST;
            r_period <= TIMER_W'(PERIOD_RST);
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_tflag  <= 1'b0;
        end else begin
            if (key_strobe) begin
                r_kcode <= key_code;
                r_kflag <= 1'b1;
            end else if (w_acc[1]) begin
                r_kflag <= 1'b0;
            end
            if (w_acc[2]) r_tape <= ~r_tape;
            if (w_acc[3]) r_beep <= ~r_beep;
            r_extra <= r_extra ^ (w_acc[8 +: EW] & XMASK);
            if (AB[15:8] == 8'hC7) r_vmode <= AB[7:0];
            // start/stop accesses take priority over an expiry in the same cycle
            if (w_acc[4]) begin
                r_en    <= 1'b1;
                r_tflag <= 1'b0;
                r_cnt   <= r_period;
            end else if (w_acc[5]) begin
                r_en    <= 1'b0;
                r_tflag <= 1'b0;
            end else if (w_run) begin
                r_tflag <= r_cnt == TIMER_W'(1) ? 1'b1 : r_tflag;
                r_cnt   <= r_cnt == TIMER_W'(1) ? r_period : r_cnt - TIMER_W'(1);
            end
            if (w_acc[6] && !read) r_period <= w_period_wr;
        end
    end
endmodule

// File: tb/tb_ag_io_page.sv
module tb_ag_io_page;
    localparam int NE = 3;
    logic phi_2 = 1'b0;
    logic reset = 1'b1;
    logic [15:0] AB = 16'h0000;
    logic read = 1'b1;
    logic [7:0] DO = 8'h00;
    logic [6:0] key_code = 7'h00;
    logic key_strobe = 1'b0;
`ifdef AG_IO_VSYNC_NMI_EN
    logic vsync = 1'b0;
`endif
    logic [7:0] dout;
    logic dout_en, tape_out, beep, nmi;
    logic [NE-1:0] extra_tgl;
    logic [7:0] vmode;
    int checks = 0;
    int failures = 0;
    logic m_kflag, m_tape, m_beep, m_en, m_tflag;
    logic [6:0] m_kcode;
    logic [NE-1:0] m_extra;
    logic [7:0] m_vmode;
    int m_period, m_next;
    int n = 0;

    ag_io_page #(.NUM_EXTRA(NE), .TIMER_W(16), .PERIOD_RST(20000), .VMODE_RST(8'h00)) dut (
        .phi_2(phi_2), .reset(reset), .AB(AB), .read(read), .DO(DO),
        .key_code(key_code), .key_strobe(key_strobe),
`ifdef AG_IO_VSYNC_NMI_EN
        .vsync(vsync),
`endif
        .dout(dout), .dout_en(dout_en), .tape_out(tape_out), .beep(beep),
        .extra_tgl(extra_tgl), .vmode(vmode), .nmi(nmi)
    );

    always #5 phi_2 = ~phi_2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // reference: the timer is tracked as the absolute edge number of the next expiry,
    // pushed back by one for every edge on which the counter is not running
    task automatic model_step();
        logic pg;
        int g, op;
        n++;
        if (reset) begin
            m_kflag = 0; m_kcode = 0; m_tape = 0; m_beep = 0; m_extra = 0; m_vmode = 8'h00;
            m_period = 20000; m_en = 0; m_tflag = 0; m_next = 0;
        end else begin
            pg = AB[15:8] == 8'hC0;
            g = int'(AB[7:4]);
            op = m_period;
            if (key_strobe) begin m_kcode = key_code; m_kflag = 1; end
            else if (pg && g == 1) m_kflag = 0;
            if (pg && g == 2) m_tape = ~m_tape;
            if (pg && g == 3) m_beep = ~m_beep;
            if (pg && g >= 8 && g < 8 + NE) m_extra[g - 8] = ~m_extra[g - 8];
            if (AB[15:8] == 8'hC7) m_vmode = AB[7:0];
            if (pg && g == 6 && !read)
                m_period = AB[0] ? ((m_period & 'hFF) | (int'(DO) << 8)) : ((m_period & 'hFF00) | int'(DO));
            if (pg && g == 4) begin m_en = 1; m_tflag = 0; m_next = n + op; end
            else if (pg && g == 5) begin m_en = 0; m_tflag = 0; m_next++; end
            else if (m_en && op != 0) begin
                if (n == m_next) begin m_tflag = 1; m_next = n + op; end
            end else m_next++;
        end
    endtask

    function automatic logic [7:0] exp_dout();
        if (!read || AB[15:8] != 8'hC0) return 8'h00;
        if (AB[7:4] == 4'h0) return {m_kflag, m_kcode};
        if (AB[7:4] == 4'hF) return {m_tflag, m_en, 6'b0};
        return 8'h00;
    endfunction

    function automatic logic exp_nmi();
`ifdef AG_IO_VSYNC_NMI_EN
        return m_en & (m_period == 0 ? vsync : m_tflag);
`else
        return m_en & m_tflag;
`endif
    endfunction

    task automatic drive(input logic [15:0] a, input logic r, input logic [7:0] d);
        AB = a; read = r; DO = d;
        #1;
        chk("dout", dout, exp_dout());
        chk("dout_en", dout_en, read && AB[15:8] == 8'hC0 && (AB[7:4] == 4'h0 || AB[7:4] == 4'hF));
    endtask

    task automatic tick();
        @(posedge phi_2);
        model_step();
        @(negedge phi_2);
        chk("tape_out", tape_out, m_tape);
        chk("beep", beep, m_beep);
        chk("extra_tgl", extra_tgl, m_extra);
        chk("vmode", vmode, m_vmode);
        chk("nmi", nmi, exp_nmi());
    endtask

    task automatic acc(input logic [15:0] a, input logic r, input logic [7:0] d);
        drive(a, r, d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic r;
        logic [7:0] d;
        int sel;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_vmode", vmode, 8'h00);
        chk("rst_nmi", nmi, 1'b0);
        chk("rst_extra", extra_tgl, 3'b000);
        // keyboard latch and strobe flag
        key_strobe = 1'b1; key_code = 7'h41;
        acc(16'h0000, 1'b1, 8'h00);
        key_strobe = 1'b0;
        drive(16'hC000, 1'b1, 8'h00);
        chk("t1_dout", dout, 8'hC1);
        chk("t1_en", dout_en, 1'b1);
        tick();
        acc(16'hC010, 1'b1, 8'h00);
        drive(16'hC000, 1'b1, 8'h00);
        chk("t1_clr", dout, 8'h41);
        tick();
        key_strobe = 1'b1; key_code = 7'h33;
        acc(16'hC010, 1'b0, 8'h00);
        key_strobe = 1'b0;
        drive(16'hC005, 1'b1, 8'h00);
        chk("t2_strobe_wins", dout, 8'hB3);
        tick();
        acc(16'hC020, 1'b1, 8'h00);
        chk("t2_tape1", tape_out, 1'b1);
        acc(16'hC02F, 1'b0, 8'h00);
        chk("t2_tape0", tape_out, 1'b0);
        // extra toggles and video mode
        acc(16'hC080, 1'b1, 8'h00);
        acc(16'hC0A3, 1'b0, 8'h00);
        chk("t3_extra", extra_tgl, 3'b101);
        acc(16'hC0B0, 1'b1, 8'h00);
        chk("t3_ignore", extra_tgl, 3'b101);
        acc(16'hC7A5, 1'b0, 8'h00);
        chk("t3_vmode", vmode, 8'hA5);
        // interval timer
        acc(16'hC060, 1'b0, 8'h0A);
        acc(16'hC061, 1'b0, 8'h00);
        acc(16'hC040, 1'b1, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            acc(16'h0000, 1'b1, 8'h00);
            chk("t4_first", nmi, 1'(i == 10));
        end
        for (int i = 0; i < 5; i++) begin
            acc(16'h0000, 1'b1, 8'h00);
            chk("t4_hold", nmi, 1'b1);
        end
        acc(16'hC040, 1'b1, 8'h00);
        chk("t4_restart", nmi, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            acc(16'h0000, 1'b1, 8'h00);
            chk("t4_second", nmi, 1'(i == 10));
        end
        acc(16'hC050, 1'b0, 8'h00);
        chk("t4_stop", nmi, 1'b0);
        for (int i = 0; i < 25; i++) begin
            acc(16'h0000, 1'b1, 8'h00);
            chk("t4_stopped", nmi, 1'b0);
        end
        // reset in the middle of a run
        acc(16'hC040, 1'b1, 8'h00);
        repeat (10) acc(16'h0000, 1'b1, 8'h00);
        chk("t5_pre_nmi", nmi, 1'b1);
        acc(16'hC020, 1'b1, 8'h00);
        chk("t5_pre_tape", tape_out, 1'b1);
        reset = 1'b1;
        acc(16'hC020, 1'b1, 8'h00);
        reset = 1'b0;
        chk("t5_nmi", nmi, 1'b0);
        chk("t5_tape", tape_out, 1'b0);
        drive(16'hC0F0, 1'b1, 8'h00);
        chk("t5_status", dout, 8'h00);
        tick();
        acc(16'hC040, 1'b1, 8'h00);
        for (int i = 0; i < 40; i++) begin
            acc(16'h0000, 1'b1, 8'h00);
            chk("t5_long_period", nmi, 1'b0);
        end
`ifdef AG_IO_VSYNC_NMI_EN
        acc(16'hC060, 1'b0, 8'h00);
        acc(16'hC061, 1'b0, 8'h00);
        acc(16'hC040, 1'b1, 8'h00);
        vsync = 1'b1;
        acc(16'h0000, 1'b1, 8'h00);
        chk("t6_vsync1", nmi, 1'b1);
        vsync = 1'b0;
        acc(16'h0000, 1'b1, 8'h00);
        chk("t6_vsync0", nmi, 1'b0);
`endif
        // randomized traffic against the reference model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc(16'hC061, 1'b0, 8'h00);
        acc(16'hC060, 1'b0, 8'h07);
        acc(16'hC040, 1'b1, 8'h00);
        for (int i = 0; i < 500; i++) begin
            sel = int'($urandom_range(0, 15));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            a = {8'hC0, 4'(sel), 4'($urandom)};
            if ((sel == 4 || sel == 5) && $urandom_range(0, 3) != 0) a = 16'h0000;
            if (sel == 6) begin
                r = 1'b0;
                d = a[0] ? 8'h00 : 8'($urandom_range(1, 30));
            end
            if (sel == 7) a = {8'hC7, 8'($urandom)};
            if (sel == 12 || sel == 13) a = {($urandom_range(0, 1) != 0) ? 8'hC1 : 8'h00, 8'($urandom)};
            key_strobe = $urandom_range(0, 7) == 0;
            key_code = 7'($urandom);
`ifdef AG_IO_VSYNC_NMI_EN
            vsync = 1'($urandom_range(0, 1));
`endif
            acc(a, r, d);
        end
        key_strobe = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
